cache_refill_ctrl: RTL

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: two-word cache line refill engine, critical word first.
// Ports: clk/rst, miss_req/miss_addr from the cache, crit_* early word,
// refill_* full line, mem_req/mem_addr/mem_rdata/mem_ack to memory, refill_count.
module cache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SET_W  = 4,
    parameter int TAG_W  = ADDR_W - 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_req,
    input  logic [ADDR_W-1:0]   miss_addr,
    output logic                busy,
    output logic                crit_valid,
    output logic [DATA_W-1:0]   crit_data,
    output logic                refill_valid,
    output logic [2*DATA_W-1:0] refill_data,
    output logic [TAG_W-1:0]    refill_tag,
    output logic [SET_W-1:0]    refill_set,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [15:0]         refill_count
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FETCH_CRIT  = 2'd1,
        FETCH_OTHER = 2'd2,
        DONE        = 2'd3
    } state_t;

    state_t                    state_q;
    logic                      busy_q;
    logic                      mem_req_q;
    logic                      refill_valid_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [1:0][DATA_W-1:0]    line_q;
    logic [1:0][DATA_W-1:0]    line_d;
    logic [DATA_W-1:0]         crit_data_q;
    logic [2*DATA_W-1:0]       refill_data_q;
    logic [TAG_W-1:0]          refill_tag_q;
    logic [SET_W-1:0]          refill_set_q;
    logic [15:0]               refill_count_q;
    logic                      word_ack;

    // Byte offset within a word never reaches memory.
    logic unused_byte_bits;
    assign unused_byte_bits = ^miss_addr[1:0];

    // An ack only counts while a request is actually outstanding.
    assign word_ack = mem_ack && (state_q == FETCH_CRIT || state_q == FETCH_OTHER);

    // addr_q[2] always points at the slot currently being fetched; it is
    // flipped after the critical word so the same bit selects both slots.
    always_comb begin
        line_d = line_q;
        if (word_ack) begin
            line_d[addr_q[2]] = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            mem_req_q      <= 1'b0;
            refill_valid_q <= 1'b0;
            addr_q         <= '0;
            line_q         <= '0;
            crit_data_q    <= '0;
            refill_data_q  <= '0;
            refill_tag_q   <= '0;
            refill_set_q   <= '0;
            refill_count_q <= '0;
        end else begin
            refill_valid_q <= 1'b0;
            line_q         <= line_d;
            unique case (state_q)
                IDLE: begin
                    if (miss_req) begin
                        addr_q    <= {miss_addr[ADDR_W-1:2], 2'b00};
                        busy_q    <= 1'b1;
                        mem_req_q <= 1'b1;
                        state_q   <= FETCH_CRIT;
                    end
                end
                FETCH_CRIT: begin
                    if (mem_ack) begin
                        crit_data_q <= mem_rdata;
                        addr_q[2]   <= ~addr_q[2];
                        state_q     <= FETCH_OTHER;
                    end
                end
                FETCH_OTHER: begin
                    if (mem_ack) begin
                        // Line outputs are loaded here so they change
                        // only as the refill_valid pulse begins.
                        mem_req_q      <= 1'b0;
                        refill_valid_q <= 1'b1;
                        refill_data_q  <= line_d;
                        refill_tag_q   <= addr_q[ADDR_W-1 -: TAG_W];
                        refill_set_q   <= addr_q[3 +: SET_W];
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    busy_q         <= 1'b0;
                    refill_count_q <= refill_count_q + 16'd1;
                    state_q        <= IDLE;
                end
            endcase
        end
    end

    // The critical word is forwarded straight from memory in its ack cycle.
    assign crit_valid   = (state_q == FETCH_CRIT) && mem_ack;
    assign crit_data    = crit_valid ? mem_rdata : crit_data_q;

    assign busy         = busy_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = addr_q;
    assign refill_valid = refill_valid_q;
    assign refill_data  = refill_data_q;
    assign refill_tag   = refill_tag_q;
    assign refill_set   = refill_set_q;
    assign refill_count = refill_count_q;

    a_pulses_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(crit_valid && refill_valid)
    );

    a_word_aligned: assert property (
        @(posedge clk) disable iff (rst) mem_addr[1:0] == 2'b00
    );

    a_req_stable: assert property (
        @(posedge clk) disable iff (rst)
        (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr))
    );

endmodule
